// File: rtl/mux_rr_arbiter.sv
// Three-requester arbiter feeding one registered 5-bit output with a
// valid/ready handshake. Round-robin or fixed priority with starvation
// promotion, selected by FIXED_PRIO.
module mux_rr_arbiter #(
  parameter int unsigned FIXED_PRIO   = 0,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [3:0] ip1,
  input  logic [3:0] ip2,
  input  logic [3:0] ip3,
  output logic [2:0] gnt,
  output logic [4:0] out_data,
  output logic [1:0] out_src,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [0:0] state;
  logic [1:0] rr_ptr;
  logic [7:0] wait_cnt [3];
  logic       load_en;
  logic       grant;
  logic [2:0] starved;
  logic [1:0] winner;
  logic [3:0] win_data;

  // Round-robin search starting one past the last winner, wrapping 2 -> 0.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] a, b, c;
    case (p)
      2'd0:    begin a = 2'd1; b = 2'd2; c = 2'd0; end
      2'd1:    begin a = 2'd2; b = 2'd0; c = 2'd1; end
      default: begin a = 2'd0; b = 2'd1; c = 2'd2; end
    endcase
    if (r[a]) return a;
    if (r[b]) return b;
    return c;
  endfunction

  // Lowest set index of a non-empty mask.
  function automatic logic [1:0] lowest(input logic [2:0] m);
    if (m[0]) return 2'd0;
    if (m[1]) return 2'd1;
    return 2'd2;
  endfunction

  assign out_valid = (state == FULL);
  assign load_en   = !out_valid || out_ready;
  assign grant     = rst_n && load_en && (|req);

  // Winner selection and combinational grant; reset forces gnt low.
  always_comb begin
    starved = '0;
    winner  = '0;
    for (int unsigned i = 0; i < 3; i++)
      starved[i] = req[i] && (wait_cnt[i] >= LIMIT);
    if (FIXED_PRIO != 0) begin
      if (|starved) winner = lowest(starved);
      else          winner = lowest(req);
    end else begin
      winner = rr_pick(req, rr_ptr);
    end
    gnt = grant ? (3'b001 << winner) : '0;
  end

  // Data mux for the selected source.
  always_comb begin
    case (winner)
      2'd0:    win_data = ip1;
      2'd1:    win_data = ip2;
      default: win_data = ip3;
    endcase
  end

  // Output register, round-robin pointer and starvation counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      out_src  <= '0;
      rr_ptr   <= 2'd2;
      for (int unsigned i = 0; i < 3; i++) wait_cnt[i] <= '0;
    end else if (grant) begin
      state    <= FULL;
      out_data <= {1'b0, win_data};
      out_src  <= winner;
      rr_ptr   <= winner;
      for (int unsigned i = 0; i < 3; i++) begin
        if (2'(i) == winner)
          wait_cnt[i] <= '0;
        else if (req[i] && (wait_cnt[i] < LIMIT))
          wait_cnt[i] <= wait_cnt[i] + 8'd1;
      end
    end else if (out_ready) begin
      state <= EMPTY;
    end
  end

endmodule
